// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT machine timer.
// Contents: the register offsets within the 64 KiB region, the ctrl field
// index, and a byte-lane merge helper that every bus-writable register uses.
package clint_pkg;

  localparam logic [15:0] OFS_MSIP   = 16'h0000;
  localparam logic [15:0] OFS_CMP    = 16'h4000;  // +8*i lo, +8*i+4 hi
  localparam logic [15:0] OFS_CTRL   = 16'h4800;  // +4*i
  localparam logic [15:0] OFS_PERIOD = 16'h4A00;  // +4*i
  localparam logic [15:0] OFS_PEND   = 16'h4C00;
  localparam logic [15:0] OFS_PRESC  = 16'hBFF0;
  localparam logic [15:0] OFS_MTIME  = 16'hBFF8;  // lo, +4 hi

  localparam int unsigned CTRL_PERIODIC = 0;

  // Bytes whose mask bit is set come from new_v; all other bytes keep old_v.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  mask);
    logic [31:0] r;
    for (int unsigned b = 0; b < 4; b++) begin
      r[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_cmp_ch.sv
// One compare channel of the CLINT timer.
// Holds cmp (64b), the periodic ctrl bit, period (32b) and the pending flag;
// performs auto-reload and drives the registered per-channel interrupt.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   mtime                current (pre-increment) timer value
//   wr_cmp_lo/hi         bus write strobes for the two cmp halves
//   wr_ctrl, wr_period   bus write strobes for ctrl and period
//   pend_clr             write-1-to-clear request for this channel's pending bit
//   wdata, wmask         bus write data and byte enables
//   cmp, periodic,
//   period, pending      register state for the read mux
//   irq                  registered timer interrupt
module clint_cmp_ch
  import clint_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] mtime,
  input  logic        wr_cmp_lo,
  input  logic        wr_cmp_hi,
  input  logic        wr_ctrl,
  input  logic        wr_period,
  input  logic        pend_clr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic [63:0] cmp,
  output logic        periodic,
  output logic [31:0] period,
  output logic        pending,
  output logic        irq
);

  logic        match;
  logic        auto_reload;
  logic        reload;
  logic        pend_set;
  logic [63:0] cmp_next;

  always_comb begin
    match       = (mtime >= cmp);
    auto_reload = periodic && (period != '0);
    reload      = auto_reload && match;
    // Periodic mode sets pending on every match, even with period=0.
    pend_set    = periodic && match;

    cmp_next = cmp;
    if (wr_cmp_lo || wr_cmp_hi) begin
      // A software write to either half suppresses that cycle's reload.
      if (wr_cmp_lo) cmp_next[31:0]  = byte_merge(cmp[31:0],  wdata, wmask);
      if (wr_cmp_hi) cmp_next[63:32] = byte_merge(cmp[63:32], wdata, wmask);
    end else if (reload) begin
      cmp_next = cmp + {32'd0, period};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmp      <= '1;
      periodic <= 1'b0;
      period   <= '0;
      pending  <= 1'b0;
      irq      <= 1'b0;
    end else begin
      cmp <= cmp_next;
      if (wr_ctrl && wmask[0]) periodic <= wdata[CTRL_PERIODIC];
      if (wr_period) period <= byte_merge(period, wdata, wmask);
      if (pend_set) begin
        pending <= 1'b1;
      end else if (pend_clr) begin
        pending <= 1'b0;
      end
      irq <= auto_reload ? pending : match;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Memory-mapped machine timer (CLINT) on the pipeline mem_* data bus.
// Holds the 64-bit mtime with prescaler, msip, address decode and the read
// mux; compare channels are clint_cmp_ch instances.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   mem_valid/mem_write  bus request strobe and direction (1=write)
//   mem_wmask, mem_wdata byte enables and write data
//   mem_addr             byte address, [1:0] ignored
//   mem_rdata            read data, valid the cycle after the request
//   irq_timer            per-channel timer interrupt (registered)
//   irq_soft             software interrupt (msip bit0, registered)
module clint_timer
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4400_0000,
  parameter int unsigned N_CMP     = 1,
  parameter int unsigned PRESC_W   = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               mem_valid,
  input  logic               mem_write,
  input  logic [3:0]         mem_wmask,
  input  logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_addr,
  output logic [31:0]        mem_rdata,
  output logic [N_CMP-1:0]   irq_timer,
  output logic               irq_soft
);

  logic               hit;
  logic [15:0]        ofs;
  logic               we;
  logic               wr_msip, wr_presc, wr_mt_lo, wr_mt_hi;
  logic               tick;
  logic [63:0]        mtime, mtime_inc, mtime_next;
  logic [PRESC_W-1:0] prescale, presc_cnt;
  logic               msip;

  logic               rd_valid, rd_hit;
  logic [15:0]        rd_ofs;
  logic [31:0]        rdata;

  logic [63:0]        ch_cmp    [N_CMP];
  logic [31:0]        ch_period [N_CMP];
  logic [N_CMP-1:0]   ch_periodic;
  logic [N_CMP-1:0]   pend_vec;

  logic               unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[1:0];

  assign hit      = (mem_addr[31:16] == BASE_ADDR[31:16]);
  assign ofs      = {mem_addr[15:2], 2'b00};
  assign we       = mem_valid && mem_write && hit;
  assign wr_msip  = we && (ofs == OFS_MSIP);
  assign wr_presc = we && (ofs == OFS_PRESC);
  assign wr_mt_lo = we && (ofs == OFS_MTIME);
  assign wr_mt_hi = we && (ofs == 16'(32'(OFS_MTIME) + 4));

  assign tick = (presc_cnt == prescale);

  always_comb begin
    mtime_inc  = tick ? mtime + 64'd1 : mtime;
    // Unwritten bytes follow the incremented value; a split write never
    // carries from the written low half into the high half.
    mtime_next = mtime_inc;
    if (wr_mt_lo) mtime_next[31:0]  = byte_merge(mtime_inc[31:0],  mem_wdata, mem_wmask);
    if (wr_mt_hi) mtime_next[63:32] = byte_merge(mtime_inc[63:32], mem_wdata, mem_wmask);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mtime     <= '0;
      prescale  <= '0;
      presc_cnt <= '0;
      msip      <= 1'b0;
      irq_soft  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_hit    <= 1'b0;
      rd_ofs    <= '0;
    end else begin
      mtime <= mtime_next;
      if (wr_presc) begin
        prescale  <= PRESC_W'(byte_merge(32'(prescale), mem_wdata, mem_wmask));
        presc_cnt <= '0;
      end else if (tick) begin
        presc_cnt <= '0;
      end else begin
        presc_cnt <= presc_cnt + 1'b1;
      end
      if (wr_msip && mem_wmask[0]) msip <= mem_wdata[0];
      irq_soft <= msip;
      if (mem_valid && !mem_write) begin
        rd_valid <= 1'b1;
        rd_hit   <= hit;
        rd_ofs   <= ofs;
      end
    end
  end

  for (genvar g = 0; g < N_CMP; g++) begin : g_ch
    clint_cmp_ch u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .mtime     (mtime),
      .wr_cmp_lo (we && (ofs == 16'(32'(OFS_CMP) + 8*g))),
      .wr_cmp_hi (we && (ofs == 16'(32'(OFS_CMP) + 8*g + 4))),
      .wr_ctrl   (we && (ofs == 16'(32'(OFS_CTRL) + 4*g))),
      .wr_period (we && (ofs == 16'(32'(OFS_PERIOD) + 4*g))),
      .pend_clr  (we && (ofs == OFS_PEND) && mem_wmask[0] && mem_wdata[g]),
      .wdata     (mem_wdata),
      .wmask     (mem_wmask),
      .cmp       (ch_cmp[g]),
      .periodic  (ch_periodic[g]),
      .period    (ch_period[g]),
      .pending   (pend_vec[g]),
      .irq       (irq_timer[g])
    );
  end

  // Read data is built from the registered address and live state.
  always_comb begin
    rdata = '1;
    if (!rd_valid) begin
      rdata = '0;
    end else if (rd_hit) begin
      if (rd_ofs == OFS_MSIP)                  rdata = {31'd0, msip};
      if (rd_ofs == OFS_PEND)                  rdata = 32'(pend_vec);
      if (rd_ofs == OFS_PRESC)                 rdata = 32'(prescale);
      if (rd_ofs == OFS_MTIME)                 rdata = mtime[31:0];
      if (rd_ofs == 16'(32'(OFS_MTIME) + 4))   rdata = mtime[63:32];
      for (int unsigned i = 0; i < N_CMP; i++) begin
        if (rd_ofs == 16'(32'(OFS_CMP) + 8*i))     rdata = ch_cmp[i][31:0];
        if (rd_ofs == 16'(32'(OFS_CMP) + 8*i + 4)) rdata = ch_cmp[i][63:32];
        if (rd_ofs == 16'(32'(OFS_CTRL) + 4*i))    rdata = {31'd0, ch_periodic[i]};
        if (rd_ofs == 16'(32'(OFS_PERIOD) + 4*i))  rdata = ch_period[i];
      end
    end
  end

  assign mem_rdata = rdata;

endmodule
